ro_capture: RTL and testbench
=============================

# ro_capture

Receive-side capture stage for the time-multiplexed event readout bus. It runs a local copy of the gray-counter slot sequence, decodes which channel owns the bus each `clk_master` cycle, samples the shared `out_mux_eve` / `out_mux_pol_eve` lines, and packs every asserted event into a timestamped word. Words are buffered in a small FWFT FIFO and released over a valid/ready handshake to the host-side serializer.

## Interface
Parameters:
- `N_CH`, 19: number of channels; equals the gray counter width and the local count width.
- `CH_W`, 5: channel index width; must satisfy 2^CH_W > N_CH.
- `TS_W`, 16: timestamp width, taken from the low bits of the local count.
- `DEPTH`, 8: FIFO depth in words; power of 2.
- `OVF_W`, 8: overflow counter width.

Ports:
- `clk_master`, in, 1: the only clock. All state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high. Asserted together with the gray counter reset.
- `bus_eve`, in, 1: shared event line, driven by the active channel's readout block.
- `bus_pol`, in, 1: shared polarity line, driven in the same slot as `bus_eve`.
- `ev_ready`, in, 1: consumer accepts the head word.
- `ev_valid`, out, 1: FIFO not empty.
- `ev_data`, out, CH_W+1+TS_W: `{ch, pol, ts}` at the FIFO head.
- `fifo_level`, out, log2(DEPTH)+1: current occupancy, 0..DEPTH.
- `ovf_count`, out, OVF_W: saturating count of events dropped while full.

## Operation
- Local binary count `cnt[N_CH-1:0]` mirrors the gray counter. It increments by 1 every cycle with reset low and wraps from 2^N_CH-1 to 0.
- Slot decode for the current cycle: `t` = number of trailing ones of `cnt`, clamped to N_CH-1. The owning channel is `ch = t+1`, giving a range of 1..N_CH.
  - Channel 1 owns every even `cnt`.
  - Channel k owns the bus once every 2^k cycles.
  - The all-ones count maps to channel N_CH.
- Capture: at each rising edge, if `bus_eve`=1, form word `{ch, bus_pol, cnt[TS_W-1:0]}` using the pre-increment `cnt`, and request a push.
  - If `bus_eve`=0, `bus_pol` is ignored and nothing is pushed.
- FIFO is first-word fall-through, built from a circular buffer with read/write pointers carrying one extra wrap bit.
  - Pop happens when `ev_valid && ev_ready`.
  - Push is accepted when not full, or when full and a pop occurs in the same cycle.
  - A push request while full with no pop is dropped, and `ovf_count` increments, saturating at 2^OVF_W-1.
- Push and pop in the same cycle leave `fifo_level` unchanged. Pop while empty is ignored.
- Reset in the middle of operation discards all buffered words. Any word presented with `ev_valid`=1 in that cycle is lost even if `ev_ready`=1.

## Timing
- Reset values after the first edge with `reset`=1: `cnt`=0, pointers 0, `ev_valid`=0, `fifo_level`=0, `ovf_count`=0, `ev_data`=0.
  - While `reset` is high, `bus_eve` is not captured.
- First cycle after reset release: `cnt`=0, so the slot belongs to channel 1.
- Latency: an event sampled at edge k into an empty FIFO gives `ev_valid`=1 and `ev_data` valid in the cycle after edge k, i.e. 1 cycle.
- `ev_data` is held stable while `ev_valid`=1 and `ev_ready`=0.
- Throughput: one push and one pop per cycle are sustained.
- `fifo_level` and `ovf_count` are registered and update on the same edge as the push or pop that changes them.
- The timestamp wraps every 2^TS_W cycles. Consumers extend it using channel ordering; this block does no extension.

## Test plan
- Reset: hold `reset`=1 for 3 cycles with `bus_eve`=1 -> `ev_valid`=0, `fifo_level`=0, `ovf_count`=0, no capture.
- Single event: `bus_eve`=1, `bus_pol`=0 in the first cycle after reset (`cnt`=0) -> next cycle `ev_valid`=1, `ev_data` = {ch=1, pol=0, ts=0}.
- Slot map: pulse `bus_eve`=1 with `bus_pol`=1 at `cnt`=3, 7 and 1023 -> words {ch=3, pol=1, ts=3}, {ch=4, pol=1, ts=7}, {ch=11, pol=1, ts=1023}.
- Backpressure/overflow: `ev_ready`=0 and `bus_eve`=1 for 10 consecutive cycles -> `fifo_level`=8, `ovf_count`=2, and the head is the first captured word.
- Full with pop: FIFO full, `ev_ready`=1 and `bus_eve`=1 in the same cycle -> level stays 8, no overflow increment, new word at the tail.
- Wrap: run to `cnt`=2^19-1 with `bus_eve`=1 -> word {ch=19, ts=0xFFFF}; the next cycle has `cnt`=0 and slot ch=1.

Source files
------------

// File: rtl/ro_capture.sv
`default_nettype none
// ============================================================================
// Module      : ro_capture
// Description : Receive-side capture of the time-multiplexed event readout
//               bus. Tracks the gray-counter slot sequence with a local binary
//               count, decodes the owning channel, packs asserted events into
//               {ch, pol, ts} words and buffers them in a FWFT FIFO drained
//               over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_capture #(
  parameter int N_CH  = 19,
  parameter int CH_W  = 5,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int OVF_W = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int DW   = CH_W + 1 + TS_W
) (
  input  logic             clk_master,
  input  logic             reset,
  input  logic             bus_eve,
  input  logic             bus_pol,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [DW-1:0]    ev_data,
  output logic [AW:0]      fifo_level,
  output logic [OVF_W-1:0] ovf_count
);

  logic [N_CH-1:0] cnt;
  logic [CH_W-1:0] t_ones;
  logic [CH_W-1:0] ch;
  logic            run;

  logic [DW-1:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic            drop;

  // Local slot counter mirroring the gray counter sequence
  always_ff @(posedge clk_master) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + N_CH'(1);
  end

  // Owning channel = trailing ones of cnt (clamped to N_CH-1) plus one
  always_comb begin
    t_ones = '0;
    run    = 1'b1;
    for (int i = 0; i < N_CH - 1; i++) begin
      if (run && cnt[i]) t_ones = t_ones + CH_W'(1);
      else               run    = 1'b0;
    end
    ch = t_ones + CH_W'(1);
  end

  // FIFO status and handshake decode; a full FIFO still accepts when popping
  always_comb begin
    ev_valid = (wr_ptr != rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop      = ev_valid && ev_ready;
    push_ok  = bus_eve && (!full || pop);
    drop     = bus_eve && full && !pop;
    ev_data  = ev_valid ? mem[rd_ptr[AW-1:0]] : '0;
  end

  // Storage write; contents need no reset since valid gates the head output
  always_ff @(posedge clk_master) begin
    if (!reset && push_ok) mem[wr_ptr[AW-1:0]] <= {ch, bus_pol, cnt[TS_W-1:0]};
  end

  // Pointer, occupancy and overflow bookkeeping
  always_ff @(posedge clk_master) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf_count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_ok && !pop)      fifo_level <= fifo_level + (AW+1)'(1);
      else if (pop && !push_ok) fifo_level <= fifo_level - (AW+1)'(1);
      if (drop && (ovf_count != {OVF_W{1'b1}})) ovf_count <= ovf_count + OVF_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ro_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ro_capture
// Description : Scoreboard bench for ro_capture. A reference model of the slot
//               counter and FIFO queues expected words at each capture edge;
//               the head, level, valid and overflow count are compared on the
//               falling edge. A second, narrow instance exercises count wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_capture;

  localparam int N_CH = 19, CH_W = 5, TS_W = 16, DEPTH = 8, OVF_W = 8;
  localparam int DW   = CH_W + 1 + TS_W;
  localparam int AW   = $clog2(DEPTH);
  // narrow instance used for the wrap boundary
  localparam int N2 = 11, C2 = 4, T2 = 11, D2 = 4, O2 = 4;
  localparam int DW2 = C2 + 1 + T2;

  logic clk = 1'b0;
  logic reset = 1'b1, bus_eve = 1'b0, bus_pol = 1'b0, ev_ready = 1'b0;
  logic ev_valid;
  logic [DW-1:0] ev_data;
  logic [AW:0] fifo_level;
  logic [OVF_W-1:0] ovf_count;

  logic eve2 = 1'b0, pol2 = 1'b0, ready2 = 1'b0;
  logic valid2;
  logic [DW2-1:0] data2;
  logic [$clog2(D2):0] level2;
  logic [O2-1:0] ovf2;

  int tests = 0, failed = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] q[$];
  longint mcnt = 0;
  int movf = 0;

  always #5 clk = ~clk;

  ro_capture #(.N_CH(N_CH), .CH_W(CH_W), .TS_W(TS_W), .DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .clk_master(clk), .reset(reset), .bus_eve(bus_eve), .bus_pol(bus_pol),
    .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_data(ev_data),
    .fifo_level(fifo_level), .ovf_count(ovf_count));

  ro_capture #(.N_CH(N2), .CH_W(C2), .TS_W(T2), .DEPTH(D2), .OVF_W(O2)) dut2 (
    .clk_master(clk), .reset(reset), .bus_eve(eve2), .bus_pol(pol2),
    .ev_ready(ready2), .ev_valid(valid2), .ev_data(data2),
    .fifo_level(level2), .ovf_count(ovf2));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // channel owning count c: k such that c+1 has exactly k-1 trailing zeros
  function automatic int exp_ch(input longint c, input int n);
    longint v = c + 1;
    for (int k = 1; k < n; k++)
      if ((v % (longint'(1) << k)) != 0) return k;
    return n;
  endfunction

  function automatic logic [DW-1:0] mk_word(input longint c, input logic p);
    logic [CH_W-1:0] chv = CH_W'(exp_ch(c, N_CH));
    logic [TS_W-1:0] ts = TS_W'(c % (longint'(1) << TS_W));
    return {chv, p, ts};
  endfunction

  // reference model: pop first, then push if space, else count the drop
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      mcnt = 0;
      movf = 0;
    end else begin
      if (q.size() > 0 && ev_ready) void'(q.pop_front());
      if (bus_eve) begin
        if (q.size() < DEPTH) q.push_back(mk_word(mcnt, bus_pol));
        else if (movf < (1 << OVF_W) - 1) movf++;
      end
      mcnt = (mcnt + 1) % (longint'(1) << N_CH);
    end
  end

  // scoreboard comparison away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 64'(ev_valid), 64'(q.size() > 0));
      check("level", 64'(fifo_level), 64'(q.size()));
      check("ovf", 64'(ovf_count), 64'(movf));
      if (q.size() > 0) check("head", 64'(ev_data), 64'(q[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input longint target);
    int n = 0;
    while (mcnt != target && n < 5000) begin
      step();
      n++;
    end
    if (mcnt != target) check("wait_timeout", 64'(mcnt), 64'(target));
  endtask

  task automatic pulse(input logic p);
    bus_eve = 1'b1; bus_pol = p;
    step();
    bus_eve = 1'b0; bus_pol = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] first_word;
    // reset held with events present: nothing captured
    reset = 1'b1; bus_eve = 1'b1; bus_pol = 1'b1;
    step();
    chk_en = 1'b1;
    step(); step();
    @(negedge clk);
    check("rst_valid", 64'(ev_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", 64'(ovf_count), 64'd0);
    check("rst_data", 64'(ev_data), 64'd0);

    // single event at cnt=0 -> channel 1
    #1; reset = 1'b0; bus_eve = 1'b1; bus_pol = 1'b0;
    step();
    bus_eve = 1'b0;
    @(negedge clk);
    check("single_valid", 64'(ev_valid), 64'd1);
    check("single_word", 64'(ev_data), 64'({5'd1, 1'b0, 16'd0}));
    #1; ev_ready = 1'b1;
    step();

    // slot map
    wait_cnt(3);    pulse(1'b1);
    @(negedge clk); check("slot3", 64'(ev_data), 64'({5'd3, 1'b1, 16'd3}));
    wait_cnt(7);    pulse(1'b1);
    @(negedge clk); check("slot7", 64'(ev_data), 64'({5'd4, 1'b1, 16'd7}));
    wait_cnt(1023); pulse(1'b1);
    @(negedge clk); check("slot1023", 64'(ev_data), 64'({5'd11, 1'b1, 16'd1023}));
    #1; step(); step();

    // backpressure and overflow: 10 events into an 8-deep FIFO
    ev_ready = 1'b0;
    first_word = mk_word(mcnt, 1'b0);
    bus_eve = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus_eve = 1'b0;
    @(negedge clk);
    check("ovf_level", 64'(fifo_level), 64'd8);
    check("ovf_count", 64'(ovf_count), 64'd2);
    check("ovf_head", 64'(ev_data), 64'(first_word));

    // full with simultaneous pop: level unchanged, no overflow
    #1; ev_ready = 1'b1; bus_eve = 1'b1;
    step();
    bus_eve = 1'b0; ev_ready = 1'b0;
    @(negedge clk);
    check("fullpop_level", 64'(fifo_level), 64'd8);
    check("fullpop_ovf", 64'(ovf_count), 64'd2);
    #1; ev_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // reset mid-operation discards buffered words even with ready high
    ev_ready = 1'b0; bus_eve = 1'b1;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1; ev_ready = 1'b1;
    step();
    reset = 1'b0; bus_eve = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(ev_valid), 64'd0);
    check("midrst_ovf", 64'(ovf_count), 64'd0);
    #1;

    // random traffic
    for (int i = 0; i < 200; i++) begin
      bus_eve  = 1'($urandom_range(0, 1));
      bus_pol  = 1'($urandom_range(0, 1));
      ev_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus_eve = 1'b0; ev_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // wrap on the narrow instance: its count equals mcnt mod 2^11
    begin
      int n = 0;
      while ((mcnt % 2048) != 2047 && n < 5000) begin step(); n++; end
      if ((mcnt % 2048) != 2047) check("wrap_timeout", 64'(mcnt % 2048), 64'd2047);
    end
    eve2 = 1'b1; pol2 = 1'b1;
    step();
    eve2 = 1'b1; pol2 = 1'b0;
    step();
    eve2 = 1'b0;
    @(negedge clk);
    check("wrap_level", 64'(level2), 64'd2);
    check("wrap_top", 64'(data2), 64'({4'd11, 1'b1, 11'h7FF}));
    #1; ready2 = 1'b1;
    step();
    ready2 = 1'b0;
    @(negedge clk);
    check("wrap_zero", 64'(data2), 64'({4'd1, 1'b0, 11'd0}));
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
